nf_scan_arbiter: RTL and testbench

//  Shares the CPU debug register-scan port (5-bit scan address out, 32-bit scan data in)

---
 rtl/nf_scan_arbiter.sv | 143 ++++++++++++++
 tb/tb_nf_scan_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nf_scan_arbiter.sv
// nf_scan_arbiter: shares the CPU debug register-scan port between NREQ consumers.
// Optional build macro NF_SCAN_ARB_PRIO_EN gives requester 0 fixed top priority.
module nf_scan_arbiter #(
    parameter int NREQ   = 3,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [5*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [31:0]       rsp_data,
    output logic [4:0]        scan_addr,
    input  logic [31:0]       scan_data,
    output logic              busy
);

    localparam int            IW   = $clog2(NREQ);
    localparam int            IW1  = IW + 1;
    localparam logic [IW:0]   NW   = IW1'(NREQ);
    localparam logic [IW-1:0] LAST = IW'(NREQ - 1);
    localparam logic [2:0]    LAT3 = 3'(RD_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] id;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_nxt;
    logic [IW-1:0] win;
    logic          win_vld;
    logic [IW:0]   idx;
    logic [2:0]    cnt;
    logic [4:0]    addr_arr [NREQ];
`ifdef NF_SCAN_ARB_PRIO_EN
    logic          prio_hold;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_addr
        assign addr_arr[i] = req_addr[5*i +: 5];
    end

    // Winner search: first requester at or after the pointer, wrapping around
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + IW1'(k);
            if (idx >= NW) idx = idx - NW;
`ifdef NF_SCAN_ARB_PRIO_EN
            if (!win_vld && idx != '0 && req[idx[IW-1:0]]) begin
`else
            if (!win_vld && req[idx[IW-1:0]]) begin
`endif
                win     = idx[IW-1:0];
                win_vld = 1'b1;
            end
        end
`ifdef NF_SCAN_ARB_PRIO_EN
        // Requester 0 wins unless it was just served and others are waiting
        if (req[0] && (!prio_hold || !win_vld)) begin
            win     = '0;
            win_vld = 1'b1;
        end
`endif
    end

    assign ptr_nxt = (win == LAST) ? '0 : win + 1'b1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (win_vld) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = (RD_LAT == 0) ? S_RESP : S_WAIT;
            S_WAIT:  if (cnt == 3'd1) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
        endcase
    end

    // Datapath: winner latch, scan address, latency counter, capture, pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id        <= '0;
            ptr       <= '0;
            scan_addr <= '0;
            cnt       <= '0;
            rsp_data  <= '0;
`ifdef NF_SCAN_ARB_PRIO_EN
            prio_hold <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (win_vld) begin
                        id        <= win;
                        scan_addr <= addr_arr[win];
`ifdef NF_SCAN_ARB_PRIO_EN
                        if (win != '0) ptr <= ptr_nxt;
                        prio_hold <= (win == '0);
`else
                        ptr       <= ptr_nxt;
`endif
                    end
                end
                S_ISSUE: begin
                    cnt <= LAT3;
                    if (RD_LAT == 0) rsp_data <= scan_data;
                end
                S_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) rsp_data <= scan_data;
                end
                S_RESP: begin
                end
            endcase
        end
    end

    // Outputs: one-cycle grant and response pulses for the latched requester
    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        busy      = (state != S_IDLE);
        if (state == S_ISSUE) gnt[id]       = 1'b1;
        if (state == S_RESP)  rsp_valid[id] = 1'b1;
    end

endmodule

// File: tb/tb_nf_scan_arbiter.sv
// tb_nf_scan_arbiter: three arbiters (RD_LAT 0, 1, 3) on shared random stimulus,
// each compared every cycle with a transaction-timestamp reference model.
module tb_nf_scan_arbiter;

    localparam int N = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req;
    logic [5*N-1:0] req_addr;
    logic [31:0]    regs [32];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int first_from(input logic [N-1:0] r, input int p);
        for (int o = 0; o < N; o++)
            if (r[(p + o) % N]) return (p + o) % N;
        return 0;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 0 : (g == 1) ? 1 : 3;

        logic [N-1:0] gnt;
        logic [N-1:0] rv;
        logic [31:0]  rd;
        logic [31:0]  sd;
        logic [4:0]   sa;
        logic         bsy;

        nf_scan_arbiter #(.NREQ(N), .RD_LAT(L)) dut (
            .clk      (clk),
            .rst      (rst),
            .req      (req),
            .req_addr (req_addr),
            .gnt      (gnt),
            .rsp_valid(rv),
            .rsp_data (rd),
            .scan_addr(sa),
            .scan_data(sd),
            .busy     (bsy)
        );

        if (L == 0) begin : g_comb
            assign sd = regs[sa];
        end else begin : g_pipe
            logic [31:0] pipe [L];
            // Register file with L cycles of read latency
            always @(posedge clk) begin
                pipe[0] <= regs[sa];
                for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
            end
            assign sd = pipe[L-1];
        end

        int          k, a, fr, w, ptr;
        bit          act, last0;
        logic [N-1:0] oth, eg, ev;
        logic        eb;
        logic [4:0]  m_addr;
        logic [31:0] e_rd;

        // Model: an accepted scan at edge a owns edges a .. a+L+2
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                k = 0; fr = 0; act = 0; ptr = 0; last0 = 0;
                w = 0; a = 0; e_rd = '0; m_addr = '0;
            end else begin
                k++;
                if (act && k == a + L + 1) e_rd = regs[m_addr];
                if (k >= fr && req != '0) begin
                    oth    = req;
                    oth[0] = 1'b0;
`ifdef NF_SCAN_ARB_PRIO_EN
                    if (req[0] && (!last0 || oth == '0)) begin
                        w = 0; last0 = 1;
                    end else begin
                        w = first_from(oth, ptr);
                        ptr = (w + 1) % N; last0 = 0;
                    end
`else
                    w   = first_from(req, ptr);
                    ptr = (w + 1) % N;
`endif
                    a = k; act = 1; fr = k + L + 3;
                    m_addr = req_addr[5*w +: 5];
                end
            end
        end

        // Compare all outputs mid-cycle
        always @(negedge clk) begin
            eg = '0;
            ev = '0;
            if (act && k == a)         eg[w] = 1'b1;
            if (act && k == a + L + 1) ev[w] = 1'b1;
            eb = act && k >= a && k <= a + L + 1;
            check($sformatf("L%0d gnt", L),       32'(gnt), 32'(eg));
            check($sformatf("L%0d rsp_valid", L), 32'(rv),  32'(ev));
            check($sformatf("L%0d rsp_data", L),  rd,       e_rd);
            check($sformatf("L%0d scan_addr", L), 32'(sa),  32'(m_addr));
            check($sformatf("L%0d busy", L),      32'(bsy), 32'(eb));
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

`ifdef NF_SCAN_ARB_PRIO_EN
    int exp_ord [6] = '{0, 1, 0, 2, 0, 1};
`else
    int exp_ord [6] = '{0, 1, 2, 0, 1, 2};
`endif

    initial begin
        int order[$];
        int got;
        int n;

        req      = '0;
        req_addr = '0;
        foreach (regs[i]) regs[i] = $urandom;
        regs[7] = 32'hDEAD_BEEF;

        #2 rst = 1'b1;
        #20 rst = 1'b0;

        // Single scan of x7 by requester 1
        req      = 3'b010;
        req_addr = 15'd7 << 5;
        repeat (2) @(negedge clk);
        #1 req = '0;
        repeat (8) @(negedge clk);

        // Rotation with all requesters held
        do_reset();
        req      = 3'b111;
        req_addr = 15'($urandom);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (g_dut[1].gnt != '0) order.push_back($clog2(g_dut[1].gnt));
        end
        for (int i = 0; i < 6; i++) begin
            got = (i < order.size()) ? order[i] : 99;
            check($sformatf("rot order %0d", i), 32'(got), 32'(exp_ord[i]));
        end

        // Single requester served back-to-back
        #1 req = 3'b100;
        repeat (20) @(negedge clk);

        // Reset while the RD_LAT=3 instance is in WAIT
        #1 req = 3'b001;
        n = 0;
        while (g_dut[2].gnt == '0 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check("mid-wait gnt seen", 32'(n < 12), 32'd1);
        #1 req = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (10) @(negedge clk);

        // Short pulses, including withdrawals while busy
        repeat (80) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) req = N'(1 << $urandom_range(0, N-1));
            else                           req = '0;
            req_addr = 15'($urandom);
        end

        // Random traffic with occasional asynchronous resets
        repeat (500) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 2) == 0) req = N'($urandom);
                req_addr = 15'($urandom);
            end
        end

        req = '0;
        repeat (8) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
